// File: rtl/cic_stereo_pkg.sv
//------------------------------------------------------------------------------
// Module : cic_stereo_pkg
// Brief  : Shared states, channel codes and default widths for the stereo CIC scheduler.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cic_stereo_pkg;

  localparam int DEF_DW    = 16;
  localparam int DEF_ERR_W = 8;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IN_IDLE = 2'd0,
    IN_L    = 2'd1,
    IN_R    = 2'd2
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_L    = 2'd0,
    OUT_R    = 2'd1,
    OUT_FULL = 2'd2
  } out_state_t;

endpackage

`default_nettype wire

// File: rtl/cic_stereo_sched_if.sv
//------------------------------------------------------------------------------
// Module : cic_stereo_sched_if
// Brief  : Upstream, decimator and downstream streams plus error sideband.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface cic_stereo_sched_if #(
  parameter int DW    = 16,
  parameter int ERR_W = 8
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_left;
  logic [DW-1:0] s_right;

  logic          cic_in_valid;
  logic          cic_in_ready;
  logic [DW-1:0] cic_in_data;
  logic          cic_in_sop;
  logic          cic_in_eop;
  logic [1:0]    cic_in_error;

  logic          cic_out_valid;
  logic          cic_out_ready;
  logic [DW-1:0] cic_out_data;
  logic          cic_out_channel;
  logic [1:0]    cic_out_error;

  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_left;
  logic [DW-1:0] m_right;

  logic             seq_err;
  logic [ERR_W-1:0] err_count;
  logic             clr_err;

  // Scheduler view
  modport master (
    input  s_valid, s_left, s_right, cic_in_ready,
           cic_out_valid, cic_out_data, cic_out_channel, cic_out_error,
           m_ready, clr_err,
    output s_ready, cic_in_valid, cic_in_data, cic_in_sop, cic_in_eop,
           cic_in_error, cic_out_ready, m_valid, m_left, m_right,
           seq_err, err_count
  );

  // Environment view (upstream, decimator, mixer)
  modport slave (
    output s_valid, s_left, s_right, cic_in_ready,
           cic_out_valid, cic_out_data, cic_out_channel, cic_out_error,
           m_ready, clr_err,
    input  s_ready, cic_in_valid, cic_in_data, cic_in_sop, cic_in_eop,
           cic_in_error, cic_out_ready, m_valid, m_left, m_right,
           seq_err, err_count
  );

endinterface

`default_nettype wire

// File: rtl/cic_lr_collect.sv
//------------------------------------------------------------------------------
// Module : cic_lr_collect
// Brief  : Reassembles decimated L/R beats into pairs; tracks order and error beats.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cic_lr_collect
  import cic_stereo_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int ERR_W = DEF_ERR_W
) (
  input  wire              clk,
  input  wire              reset,
  input  wire              out_valid,
  output logic             out_ready,
  input  wire [DW-1:0]     out_data,
  input  wire              out_channel,
  input  wire [1:0]        out_error,
  output logic             m_valid,
  input  wire              m_ready,
  output logic [DW-1:0]    m_left,
  output logic [DW-1:0]    m_right,
  input  wire              clr_err,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  out_state_t    state, state_nxt;
  logic [DW-1:0] left_reg, right_reg;
  logic          accept, store_left, store_right, seq_evt, err_evt;

  assign out_ready = (state != OUT_FULL);
  assign accept    = out_valid && out_ready;
  assign m_valid   = (state == OUT_FULL);
  assign m_left    = left_reg;
  assign m_right   = right_reg;

  always_comb begin
    state_nxt   = state;
    store_left  = 1'b0;
    store_right = 1'b0;
    seq_evt     = 1'b0;
    err_evt     = 1'b0;
    if (accept) begin
      // Errored beats take priority and also abandon any half-built pair
      if (out_error != 2'b00) begin
        err_evt   = 1'b1;
        state_nxt = OUT_L;
      end else begin
        case (state)
          OUT_L: begin
            if (out_channel == CH_LEFT) begin
              store_left = 1'b1;
              state_nxt  = OUT_R;
            end else begin
              seq_evt = 1'b1;
            end
          end
          OUT_R: begin
            if (out_channel == CH_RIGHT) begin
              store_right = 1'b1;
              state_nxt   = OUT_FULL;
            end else begin
              store_left = 1'b1;
              seq_evt    = 1'b1;
            end
          end
          default: state_nxt = OUT_L;
        endcase
      end
    end else if (state == OUT_FULL && m_ready) begin
      state_nxt = OUT_L;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= OUT_L;
      left_reg  <= '0;
      right_reg <= '0;
      seq_err   <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nxt;
      if (store_left)  left_reg  <= out_data;
      if (store_right) right_reg <= out_data;
      if (clr_err) begin
        seq_err   <= 1'b0;
        err_count <= '0;
      end else begin
        if (seq_evt) seq_err <= 1'b1;
        if (err_evt && (err_count != {ERR_W{1'b1}})) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cic_stereo_sched.sv
//------------------------------------------------------------------------------
// Module : cic_stereo_sched
// Brief  : Serialises stereo pairs into a 2-channel CIC and collects pairs back out.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cic_stereo_sched
  import cic_stereo_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int ERR_W = DEF_ERR_W
) (
  input wire                 clk,
  input wire                 reset,
  cic_stereo_sched_if.master bus
);

  in_state_t     state, state_nxt;
  logic [DW-1:0] left_hold, right_hold;
  logic          latch_pair;
  logic          s_ready, in_valid, in_sop, in_eop;
  logic [DW-1:0] in_data;

  always_comb begin
    state_nxt  = state;
    latch_pair = 1'b0;
    s_ready    = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_sop     = 1'b0;
    in_eop     = 1'b0;
    case (state)
      IN_IDLE: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
          latch_pair = 1'b1;
          state_nxt  = IN_L;
        end
      end
      IN_L: begin
        in_valid = 1'b1;
        in_data  = left_hold;
        in_sop   = 1'b1;
        if (bus.cic_in_ready) state_nxt = IN_R;
      end
      IN_R: begin
        in_valid = 1'b1;
        in_data  = right_hold;
        in_eop   = 1'b1;
        // Accepting the next pair as R leaves sustains one pair per two cycles
        s_ready  = bus.cic_in_ready;
        if (bus.cic_in_ready) begin
          if (bus.s_valid) begin
            latch_pair = 1'b1;
            state_nxt  = IN_L;
          end else begin
            state_nxt  = IN_IDLE;
          end
        end
      end
      default: state_nxt = IN_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IN_IDLE;
      left_hold  <= '0;
      right_hold <= '0;
    end else begin
      state <= state_nxt;
      if (latch_pair) begin
        left_hold  <= bus.s_left;
        right_hold <= bus.s_right;
      end
    end
  end

  assign bus.s_ready      = s_ready;
  assign bus.cic_in_valid = in_valid;
  assign bus.cic_in_data  = in_data;
  assign bus.cic_in_sop   = in_sop;
  assign bus.cic_in_eop   = in_eop;
  assign bus.cic_in_error = 2'b00;

  cic_lr_collect #(
    .DW    (DW),
    .ERR_W (ERR_W)
  ) u_collect (
    .clk         (clk),
    .reset       (reset),
    .out_valid   (bus.cic_out_valid),
    .out_ready   (bus.cic_out_ready),
    .out_data    (bus.cic_out_data),
    .out_channel (bus.cic_out_channel),
    .out_error   (bus.cic_out_error),
    .m_valid     (bus.m_valid),
    .m_ready     (bus.m_ready),
    .m_left      (bus.m_left),
    .m_right     (bus.m_right),
    .clr_err     (bus.clr_err),
    .seq_err     (bus.seq_err),
    .err_count   (bus.err_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_cic_stereo_sched.sv
//------------------------------------------------------------------------------
// Module : tb_cic_stereo_sched
// Brief  : Directed and randomized checks of the stereo CIC scheduler against a queue/pair model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cic_stereo_sched;
  import cic_stereo_pkg::*;

  localparam int DW    = 16;
  localparam int ERR_W = 8;
  typedef logic [DW+1:0] beat_t;  // {data, sop, eop}

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cic_stereo_sched_if #(.DW(DW), .ERR_W(ERR_W)) bus ();

  cic_stereo_sched #(.DW(DW), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_valid = 0; bus.s_left = '0; bus.s_right = '0; bus.cic_in_ready = 1;
    bus.cic_out_valid = 0; bus.cic_out_data = '0; bus.cic_out_channel = 0;
    bus.cic_out_error = 2'b00; bus.m_ready = 0; bus.clr_err = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    #1;
    checks++;
    if ({bus.s_ready, bus.cic_in_valid, bus.cic_in_sop, bus.cic_in_eop, bus.cic_out_ready,
         bus.m_valid, bus.seq_err} !== 7'b1000100) begin
      errors++;
      $display("FAIL reset_flags: got %b want 1000100", {bus.s_ready, bus.cic_in_valid,
               bus.cic_in_sop, bus.cic_in_eop, bus.cic_out_ready, bus.m_valid, bus.seq_err});
    end
    checks++;
    if ({bus.cic_in_data, bus.m_left, bus.m_right, bus.err_count, bus.cic_in_error} !== '0) begin
      errors++;
      $display("FAIL reset_data: in_data=%h m_left=%h m_right=%h err_count=%0d in_error=%b want all 0",
               bus.cic_in_data, bus.m_left, bus.m_right, bus.err_count, bus.cic_in_error);
    end
    tick();
    reset = 0;
  endtask

  task automatic test_basic_pair();
    bus.cic_in_ready = 1; bus.s_valid = 1; bus.s_left = 16'h1234; bus.s_right = 16'hABCD;
    #1;
    checks++;
    if ({bus.s_ready, bus.cic_in_valid} !== 2'b10) begin
      errors++; $display("FAIL basic_idle: s_ready,valid=%b want 10", {bus.s_ready, bus.cic_in_valid});
    end
    tick(); bus.s_valid = 0; #1;
    checks++;
    if ({bus.cic_in_valid, bus.cic_in_data, bus.cic_in_sop, bus.cic_in_eop} !== {1'b1, 16'h1234, 2'b10}) begin
      errors++; $display("FAIL basic_beat1: valid=%b data=%h sop=%b eop=%b want 1 1234 1 0",
                         bus.cic_in_valid, bus.cic_in_data, bus.cic_in_sop, bus.cic_in_eop);
    end
    tick(); #1;
    checks++;
    if ({bus.cic_in_valid, bus.cic_in_data, bus.cic_in_sop, bus.cic_in_eop, bus.s_ready} !==
        {1'b1, 16'hABCD, 3'b011}) begin
      errors++; $display("FAIL basic_beat2: valid=%b data=%h sop=%b eop=%b s_ready=%b want 1 abcd 0 1 1",
                         bus.cic_in_valid, bus.cic_in_data, bus.cic_in_sop, bus.cic_in_eop, bus.s_ready);
    end
    tick(); #1;
    checks++;
    if (bus.cic_in_valid !== 1'b0) begin
      errors++; $display("FAIL basic_idle_after: valid=%b want 0", bus.cic_in_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.cic_in_ready = 1; bus.s_valid = 1; bus.s_left = 16'h1111; bus.s_right = 16'h2222;
    tick(); bus.s_valid = 0;
    tick();
    bus.cic_in_ready = 0; bus.s_valid = 1; bus.s_left = 16'h3333; bus.s_right = 16'h4444;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({bus.cic_in_valid, bus.cic_in_data, bus.cic_in_eop, bus.s_ready} !== {1'b1, 16'h2222, 2'b10}) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b data=%h eop=%b s_ready=%b want 1 2222 1 0",
                           i, bus.cic_in_valid, bus.cic_in_data, bus.cic_in_eop, bus.s_ready);
      end
      tick();
    end
    bus.cic_in_ready = 1; #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: s_ready=%b want 1", bus.s_ready);
    end
    tick(); bus.s_valid = 0; #1;
    checks++;
    if ({bus.cic_in_valid, bus.cic_in_data, bus.cic_in_sop} !== {1'b1, 16'h3333, 1'b1}) begin
      errors++; $display("FAIL bp_b2b_left: valid=%b data=%h sop=%b want 1 3333 1",
                         bus.cic_in_valid, bus.cic_in_data, bus.cic_in_sop);
    end
    tick(); #1;
    checks++;
    if ({bus.cic_in_data, bus.cic_in_eop} !== {16'h4444, 1'b1}) begin
      errors++; $display("FAIL bp_b2b_right: data=%h eop=%b want 4444 1", bus.cic_in_data, bus.cic_in_eop);
    end
    tick();
  endtask

  // Pending decimator beats as a FIFO: upstream may hand over a pair whenever
  // nothing is pending or the last pending beat leaves in this cycle.
  task automatic test_random_input();
    beat_t q[$];
    logic  exp_ready;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      bus.s_valid = ($urandom_range(0, 1) == 1);
      bus.s_left  = 16'($urandom);
      bus.s_right = 16'($urandom);
      bus.cic_in_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = (q.size() == 0) || (q.size() == 1 && bus.cic_in_ready);
      checks++;
      if ({bus.cic_in_valid, bus.s_ready} !== {q.size() != 0, exp_ready}) begin
        errors++; $display("FAIL rnd_in_handshake[%0d]: valid=%b s_ready=%b want %b %b",
                           i, bus.cic_in_valid, bus.s_ready, q.size() != 0, exp_ready);
      end
      if (q.size() != 0) begin
        checks++;
        if ({bus.cic_in_data, bus.cic_in_sop, bus.cic_in_eop} !== q[0]) begin
          errors++; $display("FAIL rnd_in_beat[%0d]: data/sop/eop=%h want %h", i,
                             {bus.cic_in_data, bus.cic_in_sop, bus.cic_in_eop}, q[0]);
        end
        if (bus.cic_in_ready) void'(q.pop_front());
      end
      if (bus.s_valid && exp_ready) begin
        q.push_back({bus.s_left, 2'b10});
        q.push_back({bus.s_right, 2'b01});
      end
      tick();
    end
    bus.s_valid = 0; bus.cic_in_ready = 1;
    tick(); tick(); tick();
  endtask

  task automatic test_output_hold();
    do_reset();
    bus.cic_out_valid = 1; bus.cic_out_channel = CH_LEFT; bus.cic_out_data = 16'h0100;
    tick();
    bus.cic_out_channel = CH_RIGHT; bus.cic_out_data = 16'h0200;
    tick();
    bus.cic_out_channel = CH_LEFT; bus.cic_out_data = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.m_valid, bus.cic_out_ready, bus.m_left, bus.m_right} !== {2'b10, 16'h0100, 16'h0200}) begin
        errors++; $display("FAIL hold_pair[%0d]: m_valid=%b out_ready=%b left=%h right=%h want 1 0 0100 0200",
                           i, bus.m_valid, bus.cic_out_ready, bus.m_left, bus.m_right);
      end
      tick();
    end
    bus.cic_out_valid = 0; bus.m_ready = 1;
    tick();
    bus.m_ready = 0; #1;
    checks++;
    if ({bus.m_valid, bus.cic_out_ready} !== 2'b01) begin
      errors++; $display("FAIL hold_consumed: m_valid=%b out_ready=%b want 0 1", bus.m_valid, bus.cic_out_ready);
    end
  endtask

  task automatic test_seq_order();
    do_reset();
    bus.cic_out_valid = 1; bus.cic_out_channel = CH_RIGHT; bus.cic_out_data = 16'h7777;
    tick();
    bus.cic_out_valid = 0; #1;
    checks++;
    if ({bus.seq_err, bus.m_valid} !== 2'b10) begin
      errors++; $display("FAIL seq_flag: seq_err=%b m_valid=%b want 1 0", bus.seq_err, bus.m_valid);
    end
    bus.cic_out_valid = 1; bus.cic_out_channel = CH_LEFT; bus.cic_out_data = 16'd5;
    tick();
    bus.cic_out_channel = CH_RIGHT; bus.cic_out_data = 16'd6;
    tick();
    bus.cic_out_valid = 0; #1;
    checks++;
    if ({bus.m_valid, bus.m_left, bus.m_right} !== {1'b1, 16'd5, 16'd6}) begin
      errors++; $display("FAIL seq_recover: m_valid=%b left=%h right=%h want 1 0005 0006",
                         bus.m_valid, bus.m_left, bus.m_right);
    end
    bus.m_ready = 1; tick(); bus.m_ready = 0;
  endtask

  task automatic test_err_saturate();
    bus.cic_out_valid = 1; bus.cic_out_channel = CH_LEFT; bus.cic_out_error = 2'b01;
    for (int i = 0; i < 300; i++) begin
      bus.cic_out_data = 16'($urandom);
      tick();
      checks++;
      if (bus.m_valid !== 1'b0) begin
        errors++; $display("FAIL err_no_pair[%0d]: m_valid=%b want 0", i, bus.m_valid);
      end
      if (i == 9) begin
        checks++;
        if (bus.err_count !== 8'd10) begin
          errors++; $display("FAIL err_count10: got %0d want 10", bus.err_count);
        end
      end
    end
    bus.cic_out_valid = 0; bus.cic_out_error = 2'b00; #1;
    checks++;
    if ({bus.err_count, bus.seq_err} !== {8'd255, 1'b1}) begin
      errors++; $display("FAIL err_saturated: err_count=%0d seq_err=%b want 255 1", bus.err_count, bus.seq_err);
    end
    bus.clr_err = 1; tick(); bus.clr_err = 0; #1;
    checks++;
    if ({bus.err_count, bus.seq_err} !== 9'd0) begin
      errors++; $display("FAIL err_clear: err_count=%0d seq_err=%b want 0 0", bus.err_count, bus.seq_err);
    end
    // A clear coinciding with an error beat and an order violation leaves both cleared
    bus.clr_err = 1; bus.cic_out_valid = 1; bus.cic_out_error = 2'b10;
    tick();
    bus.cic_out_error = 2'b00; bus.cic_out_channel = CH_RIGHT;
    tick();
    bus.clr_err = 0; bus.cic_out_valid = 0; #1;
    checks++;
    if ({bus.err_count, bus.seq_err} !== 9'd0) begin
      errors++; $display("FAIL err_clear_wins: err_count=%0d seq_err=%b want 0 0", bus.err_count, bus.seq_err);
    end
  endtask

  // Pair-level model: a held left sample, a full pair slot, and the two counters.
  task automatic test_random_output();
    bit            have_l, full, mseq, ev_seq, ev_err, acc;
    int            mcnt;
    logic [DW-1:0] pl, ml, mr;
    do_reset();
    have_l = 0; full = 0; mseq = 0; mcnt = 0; pl = '0; ml = '0; mr = '0;
    for (int i = 0; i < 400; i++) begin
      bus.cic_out_valid   = ($urandom_range(0, 1) == 1);
      bus.cic_out_channel = ($urandom_range(0, 4) < 2) ? 1'b1 : 1'b0;
      bus.cic_out_data    = 16'($urandom);
      bus.cic_out_error   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.m_ready         = ($urandom_range(0, 1) == 1);
      bus.clr_err         = ($urandom_range(0, 40) == 0);
      #1;
      checks++;
      if ({bus.cic_out_ready, bus.m_valid, bus.seq_err, bus.err_count} !== {!full, full, mseq, 8'(mcnt)}) begin
        errors++; $display("FAIL rnd_out_state[%0d]: ready=%b m_valid=%b seq_err=%b err_count=%0d want %b %b %b %0d",
                           i, bus.cic_out_ready, bus.m_valid, bus.seq_err, bus.err_count, !full, full, mseq, mcnt);
      end
      if (full) begin
        checks++;
        if ({bus.m_left, bus.m_right} !== {ml, mr}) begin
          errors++; $display("FAIL rnd_out_pair[%0d]: left=%h right=%h want %h %h", i, bus.m_left, bus.m_right, ml, mr);
        end
      end
      acc = bus.cic_out_valid && !full;
      ev_seq = 0; ev_err = 0;
      if (full && bus.m_ready) full = 0;
      if (acc) begin
        if (bus.cic_out_error != 2'b00) begin
          ev_err = 1; have_l = 0;
        end else if (bus.cic_out_channel == CH_LEFT) begin
          ev_seq = have_l; have_l = 1; pl = bus.cic_out_data;
        end else if (have_l) begin
          full = 1; ml = pl; mr = bus.cic_out_data; have_l = 0;
        end else begin
          ev_seq = 1;
        end
      end
      if (bus.clr_err) begin
        mseq = 0; mcnt = 0;
      end else begin
        if (ev_seq) mseq = 1;
        if (ev_err && mcnt < 255) mcnt++;
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.s_valid = 1; bus.s_left = 16'hDEAD; bus.s_right = 16'hBEEF;
    bus.cic_out_valid = 1; bus.cic_out_channel = CH_LEFT; bus.cic_out_data = 16'h4321;
    tick();
    bus.s_valid = 0; bus.cic_out_valid = 0;
    tick();
    bus.cic_in_ready = 0;
    #2;
    reset = 1;
    #1;
    checks++;
    if ({bus.s_ready, bus.cic_in_valid, bus.cic_in_eop, bus.cic_in_data, bus.cic_out_ready, bus.m_valid} !==
        {3'b100, 16'h0000, 2'b10}) begin
      errors++; $display("FAIL async_reset: s_ready=%b valid=%b eop=%b data=%h out_ready=%b m_valid=%b want 1 0 0 0000 1 0",
                         bus.s_ready, bus.cic_in_valid, bus.cic_in_eop, bus.cic_in_data, bus.cic_out_ready, bus.m_valid);
    end
    tick();
    reset = 0; bus.cic_in_ready = 1;
    bus.s_valid = 1; bus.s_left = 16'h5A5A; bus.s_right = 16'hA5A5;
    bus.cic_out_valid = 1; bus.cic_out_channel = CH_RIGHT; bus.cic_out_data = 16'h2222;
    tick();
    bus.s_valid = 0; bus.cic_out_valid = 0; #1;
    checks++;
    if ({bus.cic_in_data, bus.cic_in_sop, bus.cic_in_eop, bus.seq_err, bus.m_valid} !== {16'h5A5A, 4'b1010}) begin
      errors++; $display("FAIL post_reset_l: data=%h sop=%b eop=%b seq_err=%b m_valid=%b want 5a5a 1 0 1 0",
                         bus.cic_in_data, bus.cic_in_sop, bus.cic_in_eop, bus.seq_err, bus.m_valid);
    end
    tick(); #1;
    checks++;
    if ({bus.cic_in_data, bus.cic_in_sop, bus.cic_in_eop} !== {16'hA5A5, 2'b01}) begin
      errors++; $display("FAIL post_reset_r: data=%h sop=%b eop=%b want a5a5 0 1",
                         bus.cic_in_data, bus.cic_in_sop, bus.cic_in_eop);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_backpressure();
    test_random_input();
    test_output_hold();
    test_seq_order();
    test_err_saturate();
    test_random_output();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cic_stereo_sched.md
Name: cic_stereo_sched

Overview:
- Sequences a 2-channel, time-interleaved 16-bit CIC decimator (decimate-by-37, Avalon-ST in/out, 1-bit out_channel) for stereo audio in the rate-converter path.
- Serialises each incoming L/R sample pair into the decimator as a two-beat packet: L with startofpacket, R with endofpacket.
- Collects the decimated L/R beats back into stereo pairs for the downstream mixer.
- Checks channel ordering and error sideband, and counts errors.

Parameters:
- DW, 16, sample width; must match the decimator data width.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_valid  in  1  upstream stereo pair valid
- s_ready  out  1  upstream ready
- s_left  in  DW  upstream left sample
- s_right  in  DW  upstream right sample
- cic_in_valid  out  1  to decimator in_valid
- cic_in_ready  in  1  from decimator in_ready
- cic_in_data  out  DW  to decimator in_data
- cic_in_sop  out  1  to in_startofpacket
- cic_in_eop  out  1  to in_endofpacket
- cic_in_error  out  2  to in_error; constant 0
- cic_out_valid  in  1  from decimator out_valid
- cic_out_ready  out  1  to decimator out_ready
- cic_out_data  in  DW  from decimator out_data
- cic_out_channel  in  1  0 = left, 1 = right
- cic_out_error  in  2  decimator error sideband
- m_valid  out  1  decimated pair valid
- m_ready  in  1  downstream ready
- m_left  out  DW  decimated left
- m_right  out  DW  decimated right
- seq_err  out  1  sticky channel-order violation flag
- err_count  out  ERR_W  saturating count of beats with nonzero cic_out_error
- clr_err  in  1  synchronous clear of seq_err and err_count

Behaviour:
- Reset (async, active-high): input FSM = IN_IDLE, output FSM = OUT_L. All outputs and data registers are 0, except s_ready = 1 and cic_out_ready = 1. Asserting reset mid-packet discards the pending pair and the partial output pair. After reset the decimator must also be reset (sharing the same reset source) so its channel phase restarts at L.
- Input FSM:
  - IN_IDLE: s_ready = 1. On s_valid, latch L/R and go to IN_L.
  - IN_L: cic_in_valid = 1, data = L, sop = 1, eop = 0. On cic_in_ready, go to IN_R.
  - IN_R: data = R, sop = 0, eop = 1. s_ready = cic_in_ready (combinational). On cic_in_ready: if s_valid, latch the new pair and go to IN_L; otherwise go to IN_IDLE.
  - Throughput: 1 pair per 2 cycles with no backpressure. cic_in_data is stable while valid is high and not yet accepted (Avalon-ST rule).
- Output FSM (sub-module cic_lr_collect):
  - cic_out_ready = 1 unless the state is OUT_FULL.
  - A beat is accepted when cic_out_valid && cic_out_ready.
  - Error rule, checked first: an accepted beat with cic_out_error != 0 is dropped. err_count increments, saturating at all-ones. The FSM returns to OUT_L and any held left sample is discarded.
  - OUT_L, channel 0: store left, go to OUT_R.
  - OUT_L, channel 1: drop the beat, set seq_err, stay in OUT_L.
  - OUT_R, channel 1: store right, go to OUT_FULL.
  - OUT_R, channel 0: overwrite left, set seq_err, stay in OUT_R.
  - OUT_FULL: m_valid = 1; m_left/m_right are held stable. On m_ready, go to OUT_L with m_valid = 0 on the next cycle.
  - Latency: m_valid rises 1 cycle after the right beat is accepted.
- Error counters:
  - clr_err clears seq_err and err_count on the next edge.
  - If clr_err coincides with a new error event, the clear wins and the event is lost.
- Input and output FSMs are independent; there is no cross-path stall except through decimator backpressure.

Decomposition:
- Package cic_stereo_pkg: input-state and output-state enums (IN_IDLE/IN_L/IN_R, OUT_L/OUT_R/OUT_FULL), CH_LEFT = 0, CH_RIGHT = 1, default widths.
- Sub-module cic_lr_collect: output FSM, pair registers, error counters.
- The top level holds the input FSM and instantiates cic_lr_collect.

Test Plan:
- Reset, then push pair L=0x1234 / R=0xABCD with cic_in_ready = 1 → beat 1: data 0x1234, sop = 1; beat 2: data 0xABCD, eop = 1; s_ready high on cycle 2.
- Hold cic_in_ready = 0 for 5 cycles during IN_R → data 0xABCD / eop stay stable, s_ready = 0; when ready rises, a back-to-back pair starts on the next cycle.
- Decimator emits ch0 = 0x0100, then ch1 = 0x0200, with m_ready = 0 → m_valid = 1 with m_left = 0x0100 and m_right = 0x0200, cic_out_ready = 0 until m_ready is pulsed; then one pair is consumed.
- Emit ch1 beat first from OUT_L → beat dropped, seq_err = 1; the subsequent ch0 = 5 / ch1 = 6 yields pair (5, 6).
- Emit ch0 with cic_out_error = 2'b01, 300 times → err_count saturates at 255; each beat is dropped with no m_valid. Then pulse clr_err → err_count = 0, seq_err = 0.
- Assert reset while in IN_R and OUT_R → all outputs go to reset values immediately (async); after release, a fresh pair produces a correct sop/eop sequence.
